// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Sequencing controller and two-way round-robin arbiter in front of the
//   single-port data memory. Port P (pipeline MEM stage) and port D
//   (debug/program loader) share the memory; each access holds the memory
//   port for LATENCY cycles, and port P sees a stall while its request is
//   outstanding.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   p_req/p_we/p_addr/p_wdata  pipeline request (held until p_ack)
//   p_rdata, p_ack, p_stall    pipeline read data, completion pulse, stall
//   d_req/d_we/d_addr/d_wdata  debug request (same semantics as port P)
//   d_rdata, d_ack             debug read data, completion pulse
//   mem_addr/mem_wdata/mem_write/mem_read/mem_rdata  memory side
//
// Addresses are byte addresses passed through unmodified; the memory
// itself performs the addr>>2 word selection.

module dmem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2   // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_ack,
  output logic              p_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic {
    OWN_P,
    OWN_D
  } owner_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t              state_q, state_d;
  owner_t              owner_q, last_grant_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                start;
  logic                grant_d;
  logic                busy;
  logic                done;

  // D wins when it is the only requester, or on a tie when P was granted last.
  assign grant_d = d_req & (~p_req | (last_grant_q == OWN_P));
  assign start   = (state_q == S_IDLE) & (p_req | d_req);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (p_req || d_req) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == '0)    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Access latch, latency counter and per-port read-data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q      <= OWN_P;
      last_grant_q <= OWN_D;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      p_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      if (start) begin
        owner_q      <= grant_d ? OWN_D : OWN_P;
        last_grant_q <= grant_d ? OWN_D : OWN_P;
        we_q         <= grant_d ? d_we    : p_we;
        addr_q       <= grant_d ? d_addr  : p_addr;
        wdata_q      <= grant_d ? d_wdata : p_wdata;
        cnt_q        <= CNT_INIT;
      end else if (state_q == S_BUSY) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - 4'd1;
        end else if (owner_q == OWN_P) begin
          p_rdata <= we_q ? '0 : mem_rdata;
        end else begin
          d_rdata <= we_q ? '0 : mem_rdata;
        end
      end
    end
  end

  assign busy = (state_q == S_BUSY);
  assign done = (state_q == S_DONE);

  // Latched address/data stay on the bus after the access; only the strobes drop.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = busy & ~we_q;
  // A single write edge per access, on the final BUSY cycle, so a reset
  // earlier in BUSY leaves memory untouched.
  assign mem_write = busy & we_q & (cnt_q == '0);

  assign p_ack   = done & (owner_q == OWN_P);
  assign d_ack   = done & (owner_q == OWN_D);
  assign p_stall = p_req & ~p_ack;

endmodule
